// File: rtl/core_arbiter.sv
// Shares one pipelined Wishbone master between the instruction and data ports (CORE_ARBITER_RR_EN: round-robin, else data priority).
// Latency: req->stb/gnt and ack/err->rvalid are combinational; owner FIFO, count and last owner update at the clock edge.
// Backpressure: wb_stall or a full owner FIFO holds both gnt low; an ungranted requester keeps req high until granted.
module core_arbiter #(
    parameter int PENDING = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic        instr_err,
    input  logic [31:0] instr_addr,
    input  logic        instr_we,
    input  logic [3:0]  instr_be,
    input  logic [31:0] instr_wdata,
    output logic [31:0] instr_rdata,
    input  logic        data_req,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic        data_err,
    input  logic [31:0] data_addr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_stall
);
    localparam int PW = $clog2(PENDING);
    localparam logic [PW:0] DEPTH = (PW+1)'(PENDING);

    logic [PENDING-1:0] owner_q;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [PW:0]        count;
    logic               full;
    logic               busy;
    logic               sel_data;
    logic               accept;
    logic               resp;
    logic               owner;

    assign full = (count == DEPTH);
    assign busy = (count != '0);

`ifdef CORE_ARBITER_RR_EN
    logic last;
    // On contention the port that did not win the previous acceptance goes first.
    assign sel_data = data_req & (~instr_req | ~last);
`else
    assign sel_data = data_req;
`endif

    assign wb_stb   = (instr_req | data_req) & ~full;
    assign accept   = wb_stb & ~wb_stall;
    assign wb_cyc   = wb_stb | busy;
    assign wb_adr   = sel_data ? data_addr  : instr_addr;
    assign wb_we    = sel_data ? data_we    : instr_we;
    assign wb_dat_o = sel_data ? data_wdata : instr_wdata;
    assign wb_sel   = wb_we ? (sel_data ? data_be : instr_be) : 4'hF;

    assign instr_gnt = accept & ~sel_data;
    assign data_gnt  = accept & sel_data;

    // Responses with nothing outstanding (e.g. stale acks after reset) are dropped here.
    assign owner        = owner_q[rptr];
    assign resp         = wb_cyc & (wb_ack | wb_err) & busy;
    assign instr_rvalid = resp & ~owner;
    assign data_rvalid  = resp & owner;
    assign instr_err    = instr_rvalid & wb_err;
    assign data_err     = data_rvalid & wb_err;
    assign instr_rdata  = wb_dat_i;
    assign data_rdata   = wb_dat_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
`ifdef CORE_ARBITER_RR_EN
            last  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                owner_q[wptr] <= sel_data;
                wptr          <= wptr + PW'(1);
`ifdef CORE_ARBITER_RR_EN
                last          <= sel_data;
`endif
            end
            if (resp) begin
                rptr <= rptr + PW'(1);
            end
            if (accept & ~resp) begin
                count <= count + (PW+1)'(1);
            end else if (~accept & resp) begin
                count <= count - (PW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_core_arbiter.sv
// Bench for core_arbiter: directed scenarios then random traffic, all checked against a queue-based owner model.
module tb_core_arbiter;
    localparam int P = 4;
`ifdef CORE_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err, instr_we;
    logic [31:0] instr_addr, instr_wdata, instr_rdata;
    logic [3:0]  instr_be;
    logic        data_req, data_gnt, data_rvalid, data_err, data_we;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;

    core_arbiter #(.PENDING(P)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid), .instr_err(instr_err),
        .instr_addr(instr_addr), .instr_we(instr_we), .instr_be(instr_be), .instr_wdata(instr_wdata),
        .instr_rdata(instr_rdata),
        .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_err(data_err),
        .data_addr(data_addr), .data_we(data_we), .data_be(data_be), .data_wdata(data_wdata),
        .data_rdata(data_rdata),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_sel(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding owners in issue order (0 = instr, 1 = data).
    int q[$];
    int gnt_log[$];
    int rsp_log[$];
    bit last = 1'b0;
    bit m_acc = 1'b0, m_sel = 1'b0, m_resp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        bit any, seld, stb, acc, resp, own, wev;
        logic [3:0] bev;
        #4;
        any = instr_req | data_req;
        if (instr_req && data_req) seld = RR ? (last == 1'b0) : 1'b1;
        else seld = data_req;
        stb  = any && (q.size() < P);
        acc  = stb && !wb_stall;
        resp = (wb_ack || wb_err) && (q.size() > 0);
        own  = (q.size() > 0) ? q[0][0] : 1'b0;
        wev  = seld ? data_we : instr_we;
        bev  = seld ? data_be : instr_be;
        chk("stb", wb_stb, stb);
        chk("cyc", wb_cyc, stb || (q.size() > 0));
        chk("instr_gnt", instr_gnt, acc && !seld);
        chk("data_gnt", data_gnt, acc && seld);
        chk("instr_rvalid", instr_rvalid, resp && !own);
        chk("data_rvalid", data_rvalid, resp && own);
        chk("instr_err", instr_err, resp && !own && wb_err);
        chk("data_err", data_err, resp && own && wb_err);
        chk("count", 32'(dut.count), q.size());
        if (stb) begin
            chk("adr", wb_adr, seld ? data_addr : instr_addr);
            chk("we", wb_we, wev);
            chk("sel", wb_sel, wev ? bev : 4'hF);
            chk("dat_o", wb_dat_o, seld ? data_wdata : instr_wdata);
        end
        if (resp) chk("rdata", own ? data_rdata : instr_rdata, wb_dat_i);
        m_acc = acc;
        m_sel = seld;
        m_resp = resp;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            last = 1'b0;
        end else begin
            if (m_resp) begin
                rsp_log.push_back(q[0]);
                void'(q.pop_front());
            end
            if (m_acc) begin
                q.push_back(int'(m_sel));
                gnt_log.push_back(int'(m_sel));
                last = m_sel;
            end
        end
        m_acc = 1'b0;
        m_resp = 1'b0;
    endtask

    task automatic step();
        sample();
        edge_();
    endtask

    function automatic logic [7:0] pack8(input int l[$]);
        logic [7:0] v = '0;
        for (int i = 0; i < 8 && i < l.size(); i++) v[i] = l[i][0];
        return v;
    endfunction

    initial begin
        int ni, nd;
        rst = 1'b1;
        instr_req = 0; instr_addr = 0; instr_we = 0; instr_be = 0; instr_wdata = 0;
        data_req = 0; data_addr = 0; data_we = 0; data_be = 0; data_wdata = 0;
        wb_ack = 0; wb_err = 0; wb_stall = 0; wb_dat_i = 0;
        #1;
        edge_();
        rst = 1'b0;
        sample();
        chk("reset_cyc", wb_cyc, 1'b0);
        chk("reset_stb", wb_stb, 1'b0);
        edge_();

        // Single instruction read, ack two cycles later.
        instr_req = 1; instr_addr = 32'h100;
        sample();
        chk("single_gnt", instr_gnt, 1'b1);
        chk("single_sel", wb_sel, 4'hF);
        chk("single_adr", wb_adr, 32'h100);
        edge_();
        instr_req = 0;
        step();
        wb_ack = 1; wb_dat_i = 32'hDEADBEEF;
        sample();
        chk("single_rvalid", instr_rvalid, 1'b1);
        chk("single_rdata", instr_rdata, 32'hDEADBEEF);
        chk("single_data_rvalid", data_rvalid, 1'b0);
        edge_();
        wb_ack = 0;

        // Contention: both ports want 4 transfers, slave acks every cycle.
        gnt_log.delete(); rsp_log.delete();
        ni = 0; nd = 0;
        for (int c = 0; c < 40 && (ni < 4 || nd < 4 || q.size() > 0); c++) begin
            instr_req = (ni < 4); data_req = (nd < 4);
            instr_addr = $urandom; data_addr = $urandom;
            instr_we = 1'($urandom); data_we = 1'($urandom);
            instr_be = 4'($urandom); data_be = 4'($urandom);
            instr_wdata = $urandom; data_wdata = $urandom;
            wb_ack = (q.size() > 0); wb_dat_i = $urandom;
            sample();
            if (m_acc) begin
                if (m_sel) nd++;
                else ni++;
            end
            edge_();
        end
        instr_req = 0; data_req = 0; wb_ack = 0;
        chk("contend_gnt_cnt", gnt_log.size(), 8);
        chk("contend_gnt_order", pack8(gnt_log), RR ? 8'h55 : 8'h0F);
        chk("contend_rsp_order", pack8(rsp_log), RR ? 8'h55 : 8'h0F);

        // Data write held under stall for three cycles.
        data_req = 1; data_we = 1; data_be = 4'b0011; data_wdata = 32'h1234; data_addr = 32'h2000;
        wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stall_gnt", data_gnt, 1'b0);
            chk("stall_sel", wb_sel, 4'b0011);
            chk("stall_we", wb_we, 1'b1);
            edge_();
        end
        wb_stall = 0;
        sample();
        chk("stall_release_gnt", data_gnt, 1'b1);
        edge_();
        data_req = 0; data_we = 0;
        wb_ack = 1;
        step();
        wb_ack = 0;

        // Fill the owner FIFO, then free one entry while blocked.
        instr_req = 1; instr_we = 0;
        for (int i = 0; i < P; i++) step();
        wb_ack = 1;
        sample();
        chk("full_stb", wb_stb, 1'b0);
        chk("full_gnt", instr_gnt, 1'b0);
        chk("full_pop_rvalid", instr_rvalid, 1'b1);
        edge_();
        wb_ack = 0;
        sample();
        chk("after_full_gnt", instr_gnt, 1'b1);
        edge_();
        instr_req = 0;
        wb_ack = 1;
        for (int i = 0; i < P; i++) step();
        wb_ack = 0;
        sample();
        chk("drain_cyc", wb_cyc, 1'b0);
        chk("drain_count", 32'(dut.count), 0);
        edge_();

        // Error on the middle of I,D,I.
        instr_req = 1; step(); instr_req = 0;
        data_req = 1; data_we = 0; step(); data_req = 0;
        instr_req = 1; step(); instr_req = 0;
        wb_ack = 1;
        sample();
        chk("err1_irv", instr_rvalid, 1'b1);
        chk("err1_ierr", instr_err, 1'b0);
        edge_();
        wb_ack = 0; wb_err = 1;
        sample();
        chk("err2_drv", data_rvalid, 1'b1);
        chk("err2_derr", data_err, 1'b1);
        edge_();
        wb_err = 0; wb_ack = 1;
        sample();
        chk("err3_irv", instr_rvalid, 1'b1);
        chk("err3_ierr", instr_err, 1'b0);
        edge_();
        wb_ack = 0;

        // Reset with three outstanding, then stale acks.
        instr_req = 1;
        for (int i = 0; i < 3; i++) step();
        instr_req = 0;
        rst = 1; step(); rst = 0;
        wb_ack = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("stale_irv", instr_rvalid, 1'b0);
            chk("stale_drv", data_rvalid, 1'b0);
            chk("stale_cyc", wb_cyc, 1'b0);
            chk("stale_count", 32'(dut.count), 0);
            edge_();
        end
        wb_ack = 0;

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            int r;
            instr_req = 1'($urandom); data_req = 1'($urandom);
            instr_addr = $urandom; data_addr = $urandom;
            instr_we = 1'($urandom); data_we = 1'($urandom);
            instr_be = 4'($urandom); data_be = 4'($urandom);
            instr_wdata = $urandom; data_wdata = $urandom;
            wb_stall = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 5);
            wb_ack = (r < 3); wb_err = (r == 3);
            wb_dat_i = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_arbiter.md
# core_arbiter

Two-requester arbiter sharing one pipelined Wishbone master between the instruction-fetch and data ports of the core. It selects one core request per cycle, drives the shared Wishbone bus, and tracks up to `PENDING` outstanding transfers in an owner FIFO. Each `ack`/`err` is routed back to the port that issued the matching request. It sits between the core and the system Wishbone interconnect, in place of two independent core-to-Wishbone bridges.

## Interface
- `PENDING`, 16: maximum outstanding (accepted, unacknowledged) transfers. Power of two, ≥ 2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `instr`  slave  `core_if`  instruction requester: `req`, `gnt`, `rvalid`, `err`, `addr[31:0]`, `we`, `be[3:0]`, `wdata[31:0]`, `rdata[31:0]`.
- `data`  slave  `core_if`  data requester; same signal set as `instr`.
- `wb`  master  `wb_if`  shared pipelined Wishbone: `cyc`, `stb`, `we`, `adr[31:0]`, `sel[3:0]`, `dat_o[31:0]`, `dat_i[31:0]`, `ack`, `err`, `stall`.

## Operation
- Owner FIFO: `PENDING` entries × 1 bit (0 = instr, 1 = data), with `count` of width `$clog2(PENDING)+1`.
  - Push on an accepted transfer (`wb.stb & ~wb.stall`).
  - Pop on `wb.cyc & (wb.ack | wb.err)` when `count > 0`.
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - Pointers wrap modulo `PENDING`.
- `full = (count == PENDING)`.
- Arbitration runs every cycle, combinationally from the current `req`s:
  - `sel_data` is set when `data.req` is the only request, or when both request and the priority rule (see Configuration) picks data.
  - With no request, `sel_data = 0`.
- `wb.stb = (instr.req | data.req) & ~full`.
- `wb.adr`, `wb.we`, `wb.dat_o` are muxed from the selected port.
- `wb.sel = we ? be : 4'hF` of the selected port.
- `wb.cyc = wb.stb | (count > 0)`.
- `gnt` of the selected port is `wb.stb & ~wb.stall`. The unselected port's `gnt = 0`; its request simply waits.
- Response routing: `owner = FIFO head`.
  - `x.rvalid = wb.cyc & (wb.ack | wb.err) & (count > 0) & (owner == x)`.
  - `x.err = x.rvalid & wb.err`.
  - `rdata` of both ports is `wb.dat_i`.
- `ack`/`err` with `count == 0` is a protocol violation: ignored, no `rvalid`, no state change.
- Requesters may switch freely between transfers. Responses return in issue order, so interleaved owners are legal.

## Timing
- Request to bus: 0 cycles. `stb`, `adr` and `gnt` are combinational from `req` and `stall`.
- Response to core: 0 cycles. `rvalid` is combinational from `ack`/`err` and the FIFO head.
- State captured at the clock edge: FIFO contents, pointers, `count`, round-robin pointer.
- Full: `stb = 0` and both `gnt = 0` that cycle. A pop in that cycle frees an entry for the next cycle, not the same one.
- Reset (`rst = 1` at an edge, including mid-burst):
  - `count`, read/write pointers and round-robin pointer clear (pointer = instr).
  - After reset, `cyc = 0`, and `stb = 0` unless `req` is held.
  - All `gnt`/`rvalid`/`err` are 0 whenever `count = 0` and no `req` is present.
  - Acks for pre-reset transfers are dropped (the `count == 0` rule).
- Counter never exceeds `PENDING` and never underflows. Assertions in the bench check both.

## Configuration
- `CORE_ARBITER_RR_EN`
  - Defined: round-robin. A 1-bit `last` register records the owner of the last accepted transfer. On contention, grant the port ≠ `last`. `last` updates only on acceptance. Reset value is instr, so the first contention goes to data.
  - Undefined: fixed priority. Data always wins on contention; instr can starve while `data.req` is held. No `last` register.

## Test plan
- Single instr read at `addr=0x100`, `stall=0`, ack 2 cycles later with `dat_i=0xDEADBEEF`:
  - `instr.gnt` in the request cycle.
  - `instr.rvalid` and `rdata=0xDEADBEEF` in the ack cycle.
  - `data.rvalid` stays 0.
  - `wb.sel=4'hF`.
- Both ports request continuously, 4 transfers each, slave acks every cycle:
  - With RR_EN: grants alternate D,I,D,I,D,I,D,I.
  - Without RR_EN: 4×D then 4×I.
  - `rvalid`s return to owners in the same order.
- Data write `be=4'b0011`, `wdata=0x1234`, `stall` high 3 cycles:
  - `data.gnt=0` while stalled.
  - `wb.sel=0011`, `we=1` held stable.
  - Grant in the 4th cycle.
- `PENDING=4`, 4 accepted transfers with no ack:
  - `stb=0`, `gnt=0` on the 5th.
  - Ack in the same cycle as the blocked request; grant occurs the next cycle.
  - `count` returns to 0 after all acks.
  - `cyc` drops the cycle after the last ack.
- `err` on the 2nd of 3 outstanding (I,D,I):
  - `data.rvalid=1` and `data.err=1`.
  - `instr.err` stays 0 on the other responses.
- Assert `rst` with 3 outstanding, then the slave sends 3 stale acks:
  - No `rvalid` on either port.
  - `cyc=0`.
  - `count` stays 0.
